page_transfer_engine: RTL and testbench

- Executes a page instruction once it has been decoded: copies one page of PAGE_WORDS words between local (core) memory and banked/device memory.
- Sits between the page instruction decoder/control path and the two memory ports.
- Control issues one `start` pulse per page instruction.
- The engine reports `busy` while copying and pulses `done` once the last word is written.

---
 rtl/page_transfer_engine_pkg.sv | 17 +
 rtl/page_transfer_engine_addr_counter.sv | 34 +++
 rtl/page_transfer_engine.sv | 149 ++++++++++++++
 tb/tb_page_transfer_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/page_transfer_engine_pkg.sv
// Shared definitions for the page transfer engine: FSM state encoding,
// transfer direction constants and the default page size.
package page_transfer_engine_pkg;

  localparam int DEFAULT_PAGE_BITS = 6;

  localparam logic DIR_LOAD  = 1'b0;  // bank -> local
  localparam logic DIR_STORE = 1'b1;  // local -> bank

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    COPY = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/page_transfer_engine_addr_counter.sv
// Read/write word-index counters for one page transfer. last flags that
// the write index sits on the final word of the page.
module page_addr_counter
  import page_transfer_engine_pkg::*;
#(
  parameter int PAGE_BITS = DEFAULT_PAGE_BITS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 rd_en,
  input  logic                 wr_en,
  output logic [PAGE_BITS-1:0] rd_idx,
  output logic [PAGE_BITS-1:0] wr_idx,
  output logic                 last
);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_idx <= '0;
      wr_idx <= '0;
    end else if (clear) begin
      rd_idx <= '0;
      wr_idx <= '0;
    end else begin
      if (rd_en) rd_idx <= rd_idx + PAGE_BITS'(1);
      if (wr_en) wr_idx <= wr_idx + PAGE_BITS'(1);
    end
  end

  assign last = &wr_idx;

endmodule

// File: rtl/page_transfer_engine.sv
// Copies one page between local and bank memory after a start pulse.
// Optional feature macro PAGE_CHECKSUM_EN adds an XOR checksum of written words.
module page_transfer_engine
  import page_transfer_engine_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int PAGE_BITS  = DEFAULT_PAGE_BITS
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         direction,
  input  logic [ADDR_WIDTH-PAGE_BITS-1:0] local_page,
  input  logic [ADDR_WIDTH-PAGE_BITS-1:0] bank_page,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        local_addr,
  output logic                         local_write_en,
  output logic [WORD_WIDTH-1:0]        local_data_out,
  input  logic [WORD_WIDTH-1:0]        local_data_in,
  output logic [ADDR_WIDTH-1:0]        bank_addr,
  output logic                         bank_write_en,
  output logic [WORD_WIDTH-1:0]        bank_data_out,
  input  logic [WORD_WIDTH-1:0]        bank_data_in,
  input  logic                         bank_ready
`ifdef PAGE_CHECKSUM_EN
  ,
  output logic [WORD_WIDTH-1:0]        checksum
`endif
);

  localparam int PN_W = ADDR_WIDTH - PAGE_BITS;

  state_t state_q, state_d;

  logic            dir_q;
  logic [PN_W-1:0] local_page_q, bank_page_q;

  // Port-level hold registers: an address or data output that is not being
  // driven this cycle keeps its previous value. During a stall this keeps the
  // source address on the last issued word, so the RAM output stays put.
  logic [ADDR_WIDTH-1:0] local_addr_q, bank_addr_q;
  logic [WORD_WIDTH-1:0] local_data_q, bank_data_q;

  logic                 accept, issue_read, write;
  logic [PAGE_BITS-1:0] rd_idx, wr_idx;
  logic                 last;

  page_addr_counter #(.PAGE_BITS(PAGE_BITS)) u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (accept),
    .rd_en   (issue_read),
    .wr_en   (write),
    .rd_idx  (rd_idx),
    .wr_idx  (wr_idx),
    .last    (last)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    issue_read = 1'b0;
    write      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        issue_read = 1'b1;
        state_d    = COPY;
      end
      COPY: begin
        if (bank_ready) begin
          write      = 1'b1;
          issue_read = !last;  // the final write has no follow-on read
          if (last) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q == READ) || (state_q == COPY);
    done           = (state_q == DONE);
    local_write_en = write && (dir_q == DIR_LOAD);
    bank_write_en  = write && (dir_q == DIR_STORE);
    local_addr     = local_addr_q;
    bank_addr      = bank_addr_q;
    local_data_out = local_data_q;
    bank_data_out  = bank_data_q;
    if (dir_q == DIR_LOAD) begin
      if (issue_read) bank_addr = {bank_page_q, rd_idx};
      if (write) begin
        local_addr     = {local_page_q, wr_idx};
        local_data_out = bank_data_in;
      end
    end else begin
      if (issue_read) local_addr = {local_page_q, rd_idx};
      if (write) begin
        bank_addr     = {bank_page_q, wr_idx};
        bank_data_out = local_data_in;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dir_q        <= DIR_LOAD;
      local_page_q <= '0;
      bank_page_q  <= '0;
      local_addr_q <= '0;
      bank_addr_q  <= '0;
      local_data_q <= '0;
      bank_data_q  <= '0;
    end else begin
      if (accept) begin
        dir_q        <= direction;
        local_page_q <= local_page;
        bank_page_q  <= bank_page;
      end
      local_addr_q <= local_addr;
      bank_addr_q  <= bank_addr;
      local_data_q <= local_data_out;
      bank_data_q  <= bank_data_out;
    end
  end

`ifdef PAGE_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (!reset_n)    checksum <= '0;
    else if (accept) checksum <= '0;
    else if (write)  checksum <= checksum ^ ((dir_q == DIR_LOAD) ? bank_data_in : local_data_in);
  end
`endif

endmodule

// File: tb/tb_page_transfer_engine.sv
// Scoreboard bench for page_transfer_engine: a page-level copy model queues
// expected writes and done events; a monitor pops and compares them.
module tb_page_transfer_engine;
  import page_transfer_engine_pkg::*;

  localparam int WW = 16;
  localparam int AW = 16;
  localparam int PB = 6;
  localparam int PW = 1 << PB;
  localparam int PN = AW - PB;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          direction = 1'b0;
  logic          bank_ready = 1'b1;
  logic [PN-1:0] local_page = '0;
  logic [PN-1:0] bank_page = '0;
  logic          busy, done, local_write_en, bank_write_en;
  logic [AW-1:0] local_addr, bank_addr;
  logic [WW-1:0] local_data_out, bank_data_out;
  logic [WW-1:0] local_data_in = '0;
  logic [WW-1:0] bank_data_in = '0;
`ifdef PAGE_CHECKSUM_EN
  logic [WW-1:0] checksum;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [WW-1:0] local_mem [0:65535];
  logic [WW-1:0] bank_mem  [0:65535];
  logic [WW-1:0] ref_local [0:65535];
  logic [WW-1:0] ref_bank  [0:65535];

  typedef struct {
    logic          dir;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;

  typedef struct {
    int            cycle;
    logic [WW-1:0] csum;
  } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  wr_t   mon_w;
  done_t mon_d;

  page_transfer_engine #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .PAGE_BITS(PB)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .direction      (direction),
    .local_page     (local_page),
    .bank_page      (bank_page),
    .busy           (busy),
    .done           (done),
    .local_addr     (local_addr),
    .local_write_en (local_write_en),
    .local_data_out (local_data_out),
    .local_data_in  (local_data_in),
    .bank_addr      (bank_addr),
    .bank_write_en  (bank_write_en),
    .bank_data_out  (bank_data_out),
    .bank_data_in   (bank_data_in),
    .bank_ready     (bank_ready)
`ifdef PAGE_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous-read RAMs with one cycle of read latency.
  always @(posedge clock) begin
    local_data_in <= local_mem[local_addr];
    bank_data_in  <= bank_mem[bank_addr];
    if (local_write_en) local_mem[local_addr] = local_data_out;
    if (bank_write_en)  bank_mem[bank_addr]   = bank_data_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every write strobe and done pulse against the queues.
  always @(negedge clock) begin
    if (reset_n) begin
      if (local_write_en || bank_write_en) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: cycle %0d strobe seen, no write expected", cyc);
        end else begin
          mon_w = wr_q.pop_front();
          check("write_strobe", {30'd0, local_write_en, bank_write_en},
                mon_w.dir ? 32'd1 : 32'd2);
          check("write_addr", mon_w.dir ? bank_addr : local_addr, mon_w.addr);
          check("write_data", mon_w.dir ? bank_data_out : local_data_out, mon_w.data);
        end
      end
      if (done) begin
        check("busy_low_at_done", busy, 0);
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: cycle %0d done seen, none expected", cyc);
        end else begin
          mon_d = done_q.pop_front();
          check("done_cycle", cyc, mon_d.cycle);
          check("writes_outstanding_at_done", wr_q.size(), 0);
`ifdef PAGE_CHECKSUM_EN
          check("checksum", checksum, mon_d.csum);
`endif
        end
      end
    end
  end

  // kind: 0 -> 0x1000+i, 1 -> i+1, 2 -> random
  task automatic fill(input logic is_bank, input int page, input int kind);
    logic [WW-1:0] v;
    for (int i = 0; i < PW; i++) begin
      case (kind)
        0:       v = WW'(16'h1000 + i);
        1:       v = WW'(i + 1);
        default: v = WW'($urandom);
      endcase
      if (is_bank) begin
        bank_mem[page * PW + i] = v;
        ref_bank[page * PW + i] = v;
      end else begin
        local_mem[page * PW + i] = v;
        ref_local[page * PW + i] = v;
      end
    end
  endtask

  // stall: 0 none, 1 five-cycle stall after word 10, 2 random stalls.
  // busy_at / reset_at are cycle offsets from the start cycle (-1 = unused).
  task automatic run_transfer(input logic dir, input int lp, input int bp,
                              input int stall, input int busy_at, input int reset_at);
    int            s, ones, k_last, k, total;
    logic          r[$];
    logic [WW-1:0] csum, v;
    int            sa, da;
    ones = 0;
    while (ones < PW) begin
      if (stall == 1)      v = (r.size() >= 11 && r.size() <= 15) ? '0 : WW'(1);
      else if (stall == 2) v = ($urandom_range(0, 3) != 0) ? WW'(1) : '0;
      else                 v = WW'(1);
      r.push_back(v[0]);
      ones += int'(v[0]);
    end
    k_last = r.size() - 1;
    total  = (reset_at >= 0) ? reset_at + 1 : k_last + 3;

    @(posedge clock); #1;
    start      = 1'b1;
    direction  = dir;
    local_page = PN'(lp);
    bank_page  = PN'(bp);
    bank_ready = 1'($urandom_range(0, 1));
    s = cyc;

    csum = '0;
    for (int i = 0; i < PW; i++) begin
      sa = (dir ? lp : bp) * PW + i;
      da = (dir ? bp : lp) * PW + i;
      v  = dir ? ref_local[sa] : ref_bank[sa];
      wr_q.push_back('{dir: dir, addr: AW'(da), data: v});
      csum ^= v;
      if (reset_at < 0) begin
        if (dir) ref_bank[da] = v;
        else     ref_local[da] = v;
      end
    end
    if (reset_at < 0) done_q.push_back('{cycle: s + k_last + 3, csum: csum});

    for (int c = 1; c <= total; c++) begin
      @(posedge clock); #1;
      start      = 1'b0;
      direction  = 1'($urandom_range(0, 1));
      local_page = PN'($urandom);
      bank_page  = PN'($urandom);
      k = c - 2;
      bank_ready = (k >= 0 && k <= k_last) ? r[k] : 1'($urandom_range(0, 1));
      if (c == 1) check("busy_after_start", busy, 1);
      if (c == busy_at) begin
        start      = 1'b1;
        local_page = PN'(lp + 1);
        bank_page  = PN'(bp + 1);
      end
      if (c == reset_at) reset_n = 1'b0;
      if (reset_at >= 0 && c == reset_at + 1) begin
        reset_n = 1'b1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_strobes", {local_write_en, bank_write_en}, 0);
        wr_q.delete();
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_local_we", local_write_en, 0);
    check("rst_bank_we", bank_write_en, 0);
    reset_n = 1'b1;

    // Load, no stalls: bank page 3 -> local page 5.
    fill(1'b1, 3, 0);
    run_transfer(DIR_LOAD, 5, 3, 0, -1, -1);
    for (int i = 0; i < PW; i++)
      check("load_page_content", local_mem[16'h0140 + i], 32'h1000 + i);

    // Store with a five-cycle stall after word 10.
    fill(1'b0, 7, 2);
    run_transfer(DIR_STORE, 7, 9, 1, -1, -1);
    for (int i = 0; i < PW; i++)
      check("store_page_content", bank_mem[9 * PW + i], ref_local[7 * PW + i]);

    // Start while busy is ignored.
    run_transfer(DIR_LOAD, 10, 3, 0, 20, -1);

    // Reset mid-transfer, then a fresh transfer completes.
    fill(1'b0, 12, 2);
    run_transfer(DIR_STORE, 12, 20, 0, -1, 30);
    run_transfer(DIR_LOAD, 13, 3, 0, -1, -1);

    // Back-to-back transfers, the second with random stalls.
    fill(1'b1, 30, 1);
    run_transfer(DIR_LOAD, 40, 30, 0, -1, -1);
    run_transfer(DIR_STORE, 40, 31, 2, -1, -1);

    // Randomized transfers.
    for (int t = 0; t < 6; t++) begin
      int lp, bp;
      logic d;
      lp = 100 + t;
      bp = 200 + t;
      d  = 1'($urandom_range(0, 1));
      fill(!d, d ? lp : bp, 2);
      run_transfer(d, lp, bp, 2, (t == 2) ? 15 : -1, -1);
    end

    repeat (4) @(posedge clock);
    #1;
    check("pending_done", done_q.size(), 0);
    check("pending_writes", wr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
